dlf_gain_scheduler: RTL

//  Sequences the digital loop filter from a bang-bang phase detector stream. Integrates lead/lag samples

---
 rtl/dlf_gain_scheduler.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dlf_gain_scheduler.sv
// Digital loop filter gain scheduler: integrates bang-bang PD samples per window and issues one
// valid/ready gain update per window. Optional holdover state enabled by DLF_SCHED_HOLDOVER_EN.
module dlf_gain_scheduler #(
    parameter int DATA_W     = 8,
    parameter int WIN_LEN    = 8,
    parameter int ACQ_SHIFT  = 4,
    parameter int TRK_SHIFT  = 1,
    parameter int LOCK_THR   = 1,
    parameter int LOCK_WINS  = 2,
    parameter int UNLOCK_THR = 4
`ifdef DLF_SCHED_HOLDOVER_EN
    ,
    parameter int HOLD_TMO   = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pd_valid,
    input  logic              pd_lead,
    output logic              dlf_upd,
    output logic              dlf_lead,
    output logic [DATA_W-1:0] dlf_gain,
    input  logic              dlf_rdy,
    output logic [1:0]        state,
    output logic              locked,
    output logic              overrun
);

    localparam int SCNT_W = $clog2(WIN_LEN);
    localparam int LCNT_W = SCNT_W + 1;
    localparam int NET_W  = LCNT_W + 2;
    localparam int QCNT_W = $clog2(LOCK_WINS + 1);
    localparam logic [31:0] GAIN_MAX = (32'd1 << DATA_W) - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SCNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [LCNT_W-1:0]   lead_cnt_q, lead_cnt_d;
    logic [QCNT_W-1:0]   quiet_q, quiet_d;
    logic                dlf_upd_q, dlf_upd_d;
    logic                dlf_lead_q, dlf_lead_d;
    logic [DATA_W-1:0]   dlf_gain_q, dlf_gain_d;
    logic                overrun_q, overrun_d;

    logic                accept;
    logic                win_close;
    logic [LCNT_W-1:0]   leads_total;
    logic signed [NET_W-1:0] net;
    logic [NET_W-1:0]    net_mag;
    logic                quiet_win;
    logic                loud_win;
    logic [QCNT_W-1:0]   quiet_inc;
    logic                lock_hit;
    logic                load;
    logic [31:0]         gain_wide;
    logic [DATA_W-1:0]   gain_sat;
    logic                hold_hit;

    // Window result is formed combinationally so it is acted on at the closing edge itself.
    always_comb begin
        accept      = enable && (state_q != ST_IDLE) && pd_valid;
        win_close   = accept && (sample_cnt_q == SCNT_W'(WIN_LEN - 1));
        leads_total = lead_cnt_q + LCNT_W'(pd_lead);
        net         = $signed({1'b0, leads_total, 1'b0}) - NET_W'(WIN_LEN);
        net_mag     = net[NET_W-1] ? $unsigned(-net) : $unsigned(net);
        quiet_win   = (net_mag <= NET_W'(LOCK_THR));
        loud_win    = (net_mag > NET_W'(UNLOCK_THR));
        quiet_inc   = quiet_win ? (quiet_q + 1'b1) : '0;
        lock_hit    = (quiet_inc == QCNT_W'(LOCK_WINS));
    end

`ifdef DLF_SCHED_HOLDOVER_EN
    localparam int ICNT_W = $clog2(HOLD_TMO + 1);

    logic [ICNT_W-1:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        hold_hit   = enable && (state_q == ST_TRACK) && !pd_valid
                     && (idle_cnt_q == ICNT_W'(HOLD_TMO - 1));
        idle_cnt_d = '0;
        if (enable && (state_q == ST_TRACK) && !pd_valid && !hold_hit) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            quiet_q <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
        end
    end

    // A sample arriving in HOLD resumes TRACK and is judged as a TRACK sample if it closes a window.
    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        if (!enable) begin
            state_d = ST_IDLE;
            quiet_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    quiet_d = '0;
                end
                ST_ACQ: begin
                    if (win_close) begin
                        if (lock_hit) begin
                            state_d = ST_TRACK;
                            quiet_d = '0;
                        end else begin
                            quiet_d = quiet_inc;
                        end
                    end
                end
                ST_TRACK: begin
                    if (win_close && loud_win) begin
                        state_d = ST_ACQ;
                    end else if (hold_hit) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (pd_valid) begin
                        state_d = (win_close && loud_win) ? ST_ACQ : ST_TRACK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state  = state_q;
        locked = (state_q == ST_TRACK) || (state_q == ST_HOLD);
    end

    // Gain uses the shift of the state being entered, so a TRACK->ACQ unlock gets acquisition gain.
    always_comb begin
        load      = win_close && (net != '0);
        gain_wide = (state_d == ST_ACQ) ? (32'(net_mag) << ACQ_SHIFT)
                                        : (32'(net_mag) << TRK_SHIFT);
        gain_sat  = (gain_wide > GAIN_MAX) ? GAIN_MAX[DATA_W-1:0] : gain_wide[DATA_W-1:0];

        sample_cnt_d = sample_cnt_q;
        lead_cnt_d   = lead_cnt_q;
        dlf_upd_d    = dlf_upd_q;
        dlf_lead_d   = dlf_lead_q;
        dlf_gain_d   = dlf_gain_q;
        overrun_d    = overrun_q;

        if (!enable) begin
            sample_cnt_d = '0;
            lead_cnt_d   = '0;
            dlf_upd_d    = 1'b0;
            dlf_lead_d   = 1'b0;
            dlf_gain_d   = '0;
            overrun_d    = 1'b0;
        end else begin
            if (win_close) begin
                sample_cnt_d = '0;
                lead_cnt_d   = '0;
            end else if (accept) begin
                sample_cnt_d = sample_cnt_q + 1'b1;
                lead_cnt_d   = leads_total;
            end

            if (load) begin
                dlf_upd_d  = 1'b1;
                dlf_lead_d = !net[NET_W-1];
                dlf_gain_d = gain_sat;
                if (dlf_upd_q && !dlf_rdy) begin
                    overrun_d = 1'b1;
                end
            end else if (dlf_upd_q && dlf_rdy) begin
                dlf_upd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
            lead_cnt_q   <= '0;
            dlf_upd_q    <= 1'b0;
            dlf_lead_q   <= 1'b0;
            dlf_gain_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            lead_cnt_q   <= lead_cnt_d;
            dlf_upd_q    <= dlf_upd_d;
            dlf_lead_q   <= dlf_lead_d;
            dlf_gain_q   <= dlf_gain_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        dlf_upd  = dlf_upd_q;
        dlf_lead = dlf_lead_q;
        dlf_gain = dlf_gain_q;
        overrun  = overrun_q;
    end

endmodule
